// File: rtl/riscv_pkg.sv
// Shared definitions for the multicycle RV32I core: FSM states, opcodes,
// datapath select encodings and the per-state control decode.
package riscv_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    typedef struct packed {
        logic       adrsrc;
        logic       memwrite;
        logic       regwrite;
        logic       pcupdate;
        logic       branch;
        logic [1:0] resultsrc;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
    } ctrl_t;

    // Moore outputs of each state; FETCH's memReady-dependent strobes are added in the top.
    function automatic ctrl_t state_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH:    begin c.alusrcb = SRCB_FOUR; c.resultsrc = RES_ALURESULT; end
            S_DECODE:   begin c.alusrca = SRCA_OLDPC; c.alusrcb = SRCB_IMM; end
            S_MEMADR:   begin c.alusrca = SRCA_RS1; c.alusrcb = SRCB_IMM; end
            S_MEMREAD:  begin c.adrsrc = 1'b1; end
            S_MEMWB:    begin c.resultsrc = RES_DATA; c.regwrite = 1'b1; end
            S_MEMWRITE: begin c.adrsrc = 1'b1; c.memwrite = 1'b1; end
            S_EXECR:    begin c.alusrca = SRCA_RS1; c.aluop = ALUOP_FUNCT; end
            S_EXECI:    begin c.alusrca = SRCA_RS1; c.alusrcb = SRCB_IMM; c.aluop = ALUOP_FUNCT; end
            S_ALUWB:    begin c.regwrite = 1'b1; end
            S_JAL:      begin c.alusrca = SRCA_OLDPC; c.alusrcb = SRCB_FOUR; c.pcupdate = 1'b1; end
            S_BEQ:      begin c.alusrca = SRCA_RS1; c.aluop = ALUOP_SUB; c.branch = 1'b1; end
            default:    begin c.alusrcb = SRCB_FOUR; c.resultsrc = RES_ALURESULT; end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_dec.sv
// ALU decoder: maps the FSM's aluOp plus instruction function bits to aluControl.
module alu_dec
    import riscv_pkg::*;
(
    input  logic [1:0] aluOp,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] aluControl
);

    // Only R-type (op[5]=1) with funct7[5] set selects subtract; addi ignores funct7.
    always_comb begin
        aluControl = ALU_ADD;
        case (aluOp)
            ALUOP_ADD: aluControl = ALU_ADD;
            ALUOP_SUB: aluControl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  aluControl = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  aluControl = ALU_SLT;
                    3'b110:  aluControl = ALU_OR;
                    3'b111:  aluControl = ALU_AND;
                    default: aluControl = ALU_ADD;
                endcase
            end
            default: aluControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control unit: Moore FSM with registered per-state controls,
// immSrc decode and the ALU decoder instance.
module multicycle_ctrl
    import riscv_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         op,
    input  logic [2:0]         funct3,
    input  logic               funct7b5,
    input  logic               zero,
    input  logic               memReady,
    output logic               pcWrite,
    output logic               adrSrc,
    output logic               memWrite,
    output logic               irWrite,
    output logic [1:0]         resultSrc,
    output logic [1:0]         aluSrcA,
    output logic [1:0]         aluSrcB,
    output logic               regWrite,
    output logic [1:0]         immSrc,
    output logic [2:0]         aluControl,
    output logic               illegalOp,
    output logic [STATE_W-1:0] stateDbg
);

    state_t state_r;
    state_t state_nxt_s;
    ctrl_t  ctrl_r;
    logic   legal_s;
    logic   fetch_ready_s;

    // Next-state selection; unreachable encodings recover to FETCH.
    always_comb begin
        state_nxt_s = S_FETCH;
        case (state_r)
            S_FETCH:    state_nxt_s = memReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_nxt_s = S_MEMADR;
                    OP_R:         state_nxt_s = S_EXECR;
                    OP_IALU:      state_nxt_s = S_EXECI;
                    OP_JAL:       state_nxt_s = S_JAL;
                    OP_BEQ:       state_nxt_s = S_BEQ;
                    default:      state_nxt_s = S_FETCH;
                endcase
            end
            S_MEMADR:   state_nxt_s = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_nxt_s = memReady ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_nxt_s = S_FETCH;
            S_MEMWRITE: state_nxt_s = memReady ? S_FETCH : S_MEMWRITE;
            S_EXECR:    state_nxt_s = S_ALUWB;
            S_EXECI:    state_nxt_s = S_ALUWB;
            S_ALUWB:    state_nxt_s = S_FETCH;
            S_JAL:      state_nxt_s = S_ALUWB;
            S_BEQ:      state_nxt_s = S_FETCH;
            default:    state_nxt_s = S_FETCH;
        endcase
    end

    // State and its controls registered together so outputs come straight from flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_FETCH;
            ctrl_r  <= state_ctrl(S_FETCH);
        end else begin
            state_r <= state_nxt_s;
            ctrl_r  <= state_ctrl(state_nxt_s);
        end
    end

    // Opcode legality and sign-extender format, both purely from op.
    always_comb begin
        legal_s = 1'b0;
        immSrc  = IMM_I;
        case (op)
            OP_LW:   begin legal_s = 1'b1; immSrc = IMM_I; end
            OP_IALU: begin legal_s = 1'b1; immSrc = IMM_I; end
            OP_R:    begin legal_s = 1'b1; immSrc = IMM_I; end
            OP_SW:   begin legal_s = 1'b1; immSrc = IMM_S; end
            OP_BEQ:  begin legal_s = 1'b1; immSrc = IMM_B; end
            OP_JAL:  begin legal_s = 1'b1; immSrc = IMM_J; end
            default: begin legal_s = 1'b0; immSrc = IMM_I; end
        endcase
    end

    // Reset gates the input-dependent strobes so nothing fires while it is held.
    assign fetch_ready_s = (state_r == S_FETCH) & memReady & ~reset;
    assign irWrite       = fetch_ready_s;
    assign pcWrite       = fetch_ready_s | ((ctrl_r.pcupdate | (ctrl_r.branch & zero)) & ~reset);
    assign illegalOp     = (state_r == S_DECODE) & ~legal_s & ~reset;
    assign adrSrc        = ctrl_r.adrsrc;
    assign memWrite      = ctrl_r.memwrite;
    assign regWrite      = ctrl_r.regwrite;
    assign resultSrc     = ctrl_r.resultsrc;
    assign aluSrcA       = ctrl_r.alusrca;
    assign aluSrcB       = ctrl_r.alusrcb;
    assign stateDbg      = STATE_W'(state_r);

    alu_dec u_alu_dec (
        .aluOp      (ctrl_r.aluop),
        .funct3     (funct3),
        .op5        (op[5]),
        .funct7b5   (funct7b5),
        .aluControl (aluControl)
    );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl.
module tb_multicycle_ctrl;
    import riscv_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       memReady;
    logic       pcWrite, adrSrc, memWrite, irWrite, regWrite, illegalOp;
    logic [1:0] resultSrc, aluSrcA, aluSrcB, immSrc;
    logic [2:0] aluControl;
    logic [3:0] stateDbg;

    int tests  = 0;
    int failed = 0;

    multicycle_ctrl #(.STATE_W(4)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .memReady(memReady), .pcWrite(pcWrite), .adrSrc(adrSrc),
        .memWrite(memWrite), .irWrite(irWrite), .resultSrc(resultSrc),
        .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .regWrite(regWrite), .immSrc(immSrc),
        .aluControl(aluControl), .illegalOp(illegalOp), .stateDbg(stateDbg)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; memReady = 1'b1; op = OP_LW; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;
        #2;
        tests++; if ({pcWrite, irWrite, memWrite, regWrite, illegalOp} !== 5'b00000) begin failed++; $display("FAIL reset_strobes: got %b want 00000", {pcWrite, irWrite, memWrite, regWrite, illegalOp}); end
        tests++; if (stateDbg !== 4'd0) begin failed++; $display("FAIL reset_state: got %0d want 0", stateDbg); end
        tests++; if ({adrSrc, aluSrcA, aluSrcB, resultSrc} !== 7'b0_00_10_10) begin failed++; $display("FAIL reset_selects: got %b want 0001010", {adrSrc, aluSrcA, aluSrcB, resultSrc}); end
        tick(); tick();
        tests++; if ({irWrite, stateDbg} !== 5'b0_0000) begin failed++; $display("FAIL reset_held: got %b want 00000", {irWrite, stateDbg}); end
        reset = 1'b0; memReady = 1'b0;
        #1;
        tests++; if ({irWrite, pcWrite, stateDbg} !== 6'b00_0000) begin failed++; $display("FAIL reset_release: got %b want 000000", {irWrite, pcWrite, stateDbg}); end
    endtask

    task automatic test_add();
        op = OP_R; funct3 = 3'b000; funct7b5 = 1'b0; memReady = 1'b1;
        #1;
        tests++; if ({stateDbg, irWrite, pcWrite, immSrc, regWrite} !== 9'b0000_1_1_00_0) begin failed++; $display("FAIL add_fetch: got %b want 000011000", {stateDbg, irWrite, pcWrite, immSrc, regWrite}); end
        tick();
        tests++; if ({stateDbg, aluSrcA, aluSrcB, regWrite} !== 9'b0001_01_01_0) begin failed++; $display("FAIL add_decode: got %b want 000101010", {stateDbg, aluSrcA, aluSrcB, regWrite}); end
        tick();
        tests++; if ({stateDbg, aluSrcA, aluSrcB, aluControl, regWrite} !== 12'b0110_10_00_000_0) begin failed++; $display("FAIL add_execr: got %b want 011010000000", {stateDbg, aluSrcA, aluSrcB, aluControl, regWrite}); end
        tick();
        tests++; if ({stateDbg, resultSrc, regWrite} !== 7'b1000_00_1) begin failed++; $display("FAIL add_aluwb: got %b want 1000001", {stateDbg, resultSrc, regWrite}); end
        memReady = 1'b0;
        tick();
        tests++; if ({stateDbg, regWrite} !== 5'b0000_0) begin failed++; $display("FAIL add_back_fetch: got %b want 00000", {stateDbg, regWrite}); end
    endtask

    task automatic test_lw();
        op = OP_LW; memReady = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            tests++; if ({stateDbg, irWrite, pcWrite} !== 6'b0000_00) begin failed++; $display("FAIL lw_fetch_wait%0d: got %b want 000000", i, {stateDbg, irWrite, pcWrite}); end
            tick();
        end
        memReady = 1'b1;
        #1;
        tests++; if ({stateDbg, irWrite, immSrc} !== 7'b0000_1_00) begin failed++; $display("FAIL lw_fetch_ready: got %b want 0000100", {stateDbg, irWrite, immSrc}); end
        tick(); memReady = 1'b0;
        tick();
        tests++; if ({stateDbg, aluSrcA, aluSrcB, aluControl} !== 11'b0010_10_01_000) begin failed++; $display("FAIL lw_memadr: got %b want 00101001000", {stateDbg, aluSrcA, aluSrcB, aluControl}); end
        tick();
        for (int i = 0; i < 3; i++) begin
            tests++; if ({stateDbg, adrSrc, regWrite} !== 6'b0011_1_0) begin failed++; $display("FAIL lw_memread_wait%0d: got %b want 001110", i, {stateDbg, adrSrc, regWrite}); end
            tick();
        end
        memReady = 1'b1;
        #1;
        tests++; if (stateDbg !== 4'd3) begin failed++; $display("FAIL lw_memread_ready: got %0d want 3", stateDbg); end
        tick(); memReady = 1'b0;
        tests++; if ({stateDbg, resultSrc, regWrite} !== 7'b0100_01_1) begin failed++; $display("FAIL lw_memwb: got %b want 0100011", {stateDbg, resultSrc, regWrite}); end
        tick();
        tests++; if ({stateDbg, regWrite} !== 5'b0000_0) begin failed++; $display("FAIL lw_back_fetch: got %b want 00000", {stateDbg, regWrite}); end
    endtask

    task automatic test_sw();
        logic saw_reg;
        saw_reg = 1'b0;
        op = OP_SW; memReady = 1'b1;
        #1;
        tests++; if (immSrc !== 2'b01) begin failed++; $display("FAIL sw_immsrc: got %b want 01", immSrc); end
        tick(); saw_reg |= regWrite;
        tick(); saw_reg |= regWrite;
        memReady = 1'b0;
        tick();
        for (int i = 0; i < 2; i++) begin
            saw_reg |= regWrite;
            tests++; if ({stateDbg, memWrite, adrSrc} !== 6'b0101_1_1) begin failed++; $display("FAIL sw_memwrite_wait%0d: got %b want 010111", i, {stateDbg, memWrite, adrSrc}); end
            tick();
        end
        memReady = 1'b1;
        #1; saw_reg |= regWrite;
        tests++; if ({stateDbg, memWrite} !== 5'b0101_1) begin failed++; $display("FAIL sw_memwrite_ready: got %b want 01011", {stateDbg, memWrite}); end
        tick(); memReady = 1'b0; saw_reg |= regWrite;
        tests++; if ({stateDbg, memWrite} !== 5'b0000_0) begin failed++; $display("FAIL sw_back_fetch: got %b want 00000", {stateDbg, memWrite}); end
        tests++; if (saw_reg !== 1'b0) begin failed++; $display("FAIL sw_no_regwrite: got %b want 0", saw_reg); end
    endtask

    task automatic test_beq();
        for (int z = 1; z >= 0; z--) begin
            op = OP_BEQ; memReady = 1'b1; zero = z[0];
            #1;
            tests++; if (immSrc !== 2'b10) begin failed++; $display("FAIL beq_immsrc: got %b want 10", immSrc); end
            tick(); memReady = 1'b0;
            tick();
            tests++; if ({stateDbg, pcWrite, aluControl, aluSrcA, aluSrcB} !== {4'd10, z[0], 3'b001, 2'b10, 2'b00}) begin failed++; $display("FAIL beq_exec_z%0d: got %b want %b", z, {stateDbg, pcWrite, aluControl, aluSrcA, aluSrcB}, {4'd10, z[0], 3'b001, 2'b10, 2'b00}); end
            tick();
            tests++; if ({stateDbg, pcWrite} !== 5'b0000_0) begin failed++; $display("FAIL beq_latency_z%0d: got %b want 00000", z, {stateDbg, pcWrite}); end
        end
        zero = 1'b0;
    endtask

    task automatic test_jal();
        op = OP_JAL; memReady = 1'b1;
        #1;
        tests++; if (immSrc !== 2'b11) begin failed++; $display("FAIL jal_immsrc: got %b want 11", immSrc); end
        tick(); memReady = 1'b0;
        tick();
        tests++; if ({stateDbg, pcWrite, aluSrcA, aluSrcB, regWrite} !== 10'b1001_1_01_10_0) begin failed++; $display("FAIL jal_exec: got %b want 1001101100", {stateDbg, pcWrite, aluSrcA, aluSrcB, regWrite}); end
        tick();
        tests++; if ({stateDbg, regWrite, pcWrite, resultSrc} !== 8'b1000_1_0_00) begin failed++; $display("FAIL jal_aluwb: got %b want 10001000", {stateDbg, regWrite, pcWrite, resultSrc}); end
        tick();
        tests++; if (stateDbg !== 4'd0) begin failed++; $display("FAIL jal_back_fetch: got %0d want 0", stateDbg); end
    endtask

    task automatic test_alu_decode();
        logic [6:0] t_op [8] = '{OP_R, OP_R, OP_IALU, OP_IALU, OP_R, OP_IALU, OP_R, OP_IALU};
        logic [2:0] t_f3 [8] = '{3'b000, 3'b000, 3'b000, 3'b010, 3'b110, 3'b111, 3'b001, 3'b100};
        logic       t_f7 [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [2:0] t_ac [8] = '{3'b000, 3'b001, 3'b000, 3'b101, 3'b011, 3'b010, 3'b000, 3'b000};
        logic [3:0] t_st [8] = '{4'd6, 4'd6, 4'd7, 4'd7, 4'd6, 4'd7, 4'd6, 4'd7};
        for (int i = 0; i < 8; i++) begin
            op = t_op[i]; funct3 = t_f3[i]; funct7b5 = t_f7[i]; memReady = 1'b1;
            tick(); memReady = 1'b0;
            tick();
            tests++; if ({stateDbg, aluControl} !== {t_st[i], t_ac[i]}) begin failed++; $display("FAIL alu_vec%0d: got %b want %b", i, {stateDbg, aluControl}, {t_st[i], t_ac[i]}); end
            tick(); tick();
        end
        funct3 = 3'b000; funct7b5 = 1'b0;
    endtask

    task automatic test_illegal();
        op = 7'b1111111; memReady = 1'b1;
        #1;
        tests++; if ({illegalOp, immSrc} !== 3'b0_00) begin failed++; $display("FAIL illegal_fetch: got %b want 000", {illegalOp, immSrc}); end
        tick(); memReady = 1'b0;
        tests++; if ({stateDbg, illegalOp, regWrite, memWrite, pcWrite} !== 8'b0001_1_000) begin failed++; $display("FAIL illegal_decode: got %b want 00011000", {stateDbg, illegalOp, regWrite, memWrite, pcWrite}); end
        tick();
        tests++; if ({stateDbg, illegalOp} !== 5'b0000_0) begin failed++; $display("FAIL illegal_back_fetch: got %b want 00000", {stateDbg, illegalOp}); end
    endtask

    task automatic test_reset_mid_store();
        op = OP_SW; memReady = 1'b1;
        tick(); memReady = 1'b0;
        tick(); tick();
        tests++; if ({stateDbg, memWrite} !== 5'b0101_1) begin failed++; $display("FAIL rstmid_in_memwrite: got %b want 01011", {stateDbg, memWrite}); end
        #2 reset = 1'b1;
        #1;
        tests++; if ({stateDbg, memWrite, adrSrc} !== 6'b0000_0_0) begin failed++; $display("FAIL rstmid_abort: got %b want 000000", {stateDbg, memWrite, adrSrc}); end
        tick();
        reset = 1'b0;
        #1;
        tests++; if ({stateDbg, memWrite} !== 5'b0000_0) begin failed++; $display("FAIL rstmid_release: got %b want 00000", {stateDbg, memWrite}); end
        tick();
        tests++; if (stateDbg !== 4'd0) begin failed++; $display("FAIL rstmid_idle: got %0d want 0", stateDbg); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_lw();
        test_sw();
        test_beq();
        test_jal();
        test_alu_decode();
        test_illegal();
        test_reset_mid_store();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Control unit for the multicycle RV32I core.
- A Moore FSM sequences fetch, decode, execute, memory and writeback.
- Drives datapath mux selects, write strobes and the ALU operation.
- Drives the 2-bit immSrc select of the immediate sign-extender (00 I, 01 S, 10 B, 11 J), decoded from the opcode.
- Waits on a memory-ready handshake during instruction fetch, load and store.

Parameters:
STATE_W, 4, width of state register / stateDbg (11 states used)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
op  in  7  instr[6:0]
funct3  in  3  instr[14:12]
funct7b5  in  1  instr[30]
zero  in  1  ALU zero flag
memReady  in  1  memory completes current access this cycle
pcWrite  out  1  PC register enable
adrSrc  out  1  memory address: 0 PC, 1 ALUOut
memWrite  out  1  store strobe
irWrite  out  1  instruction/oldPC register enable
resultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
aluSrcA  out  2  00 PC, 01 oldPC, 10 rs1 data
aluSrcB  out  2  00 rs2 data, 01 immExt, 10 constant 4
regWrite  out  1  register file write enable
immSrc  out  2  sign-extender format select
aluControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
illegalOp  out  1  one-cycle pulse for an unsupported opcode
stateDbg  out  STATE_W  current state

Behaviour:
- Reset:
  - State is forced to FETCH asynchronously.
  - While reset=1, pcWrite, irWrite, memWrite, regWrite and illegalOp are 0.
  - Other outputs follow the FETCH decode.
- Opcodes:
  - LW 0000011, SW 0100011, R 0110011, IALU 0010011, BEQ 1100011, JAL 1101111.
- Internal Moore signals:
  - pcUpdate and branch.
  - aluOp: 00 add, 01 sub, 10 funct decode.
- pcWrite is combinational: pcUpdate | (branch & zero).
- States, outputs and next state (unlisted selects are 00, unlisted strobes 0):
  - FETCH: adrSrc=0, aluSrcA=00, aluSrcB=10, aluOp=00, resultSrc=10.
    - irWrite=pcUpdate=memReady.
    - Stays in FETCH while memReady=0; goes to DECODE when memReady=1.
  - DECODE: aluSrcA=01, aluSrcB=01, aluOp=00 (computes the branch target).
    - LW/SW go to MEMADR; R goes to EXECR; IALU goes to EXECI; JAL goes to JAL; BEQ goes to BEQ.
    - Any other opcode: illegalOp=1, next FETCH, no architectural write.
  - MEMADR: aluSrcA=10, aluSrcB=01, aluOp=00.
    - LW goes to MEMREAD, SW goes to MEMWRITE.
  - MEMREAD: adrSrc=1, resultSrc=00.
    - Waits for memReady, then goes to MEMWB.
  - MEMWB: resultSrc=01, regWrite=1, next FETCH.
  - MEMWRITE: adrSrc=1, resultSrc=00, memWrite=1.
    - memWrite is held until the cycle memReady=1, then next FETCH.
  - EXECR: aluSrcA=10, aluSrcB=00, aluOp=10, next ALUWB.
  - EXECI: aluSrcA=10, aluSrcB=01, aluOp=10, next ALUWB.
  - ALUWB: resultSrc=00, regWrite=1, next FETCH.
  - JAL: aluSrcA=01, aluSrcB=10, aluOp=00, resultSrc=00, pcUpdate=1, next ALUWB (writes rd=PC+4).
  - BEQ: aluSrcA=10, aluSrcB=00, aluOp=01, resultSrc=00, branch=1, next FETCH.
- immSrc (combinational on op, independent of state):
  - LW/IALU give 00; SW gives 01; BEQ gives 10; JAL gives 11; anything else gives 00.
- ALU decoder (combinational):
  - aluOp 00 gives add; aluOp 01 gives sub.
  - aluOp 10 decodes funct3:
    - 000: sub if op[5]&funct7b5, else add.
    - 010: slt.
    - 110: or.
    - 111: and.
    - Any other funct3: add.
- Latency in cycles, excluding memReady waits: R/I 4, LW 5, SW 4, BEQ 3, JAL 4.
- Reset asserted mid-operation aborts the instruction in the same cycle: no strobe after reset rises, FETCH on release.
- Unreachable state encodings go to FETCH.

Decomposition:
- Shared package (riscv_pkg), used by the datapath and bench:
  - State enumeration.
  - Opcode constants.
  - immSrc, aluControl, resultSrc, aluSrcA and aluSrcB encodings.
- Sub-module alu_dec (aluOp, funct3, op[5], funct7b5 -> aluControl), instanced once.
- FSM and immSrc decode stay in multicycle_ctrl.

Test Plan:
1. add x3,x1,x2 (op 0110011, f3 000, f7b5 0), memReady=1 -> states FETCH, DECODE, EXECR, ALUWB; aluControl=000 in EXECR; regWrite=1 only in cycle 4; immSrc=00.
2. lw, memReady low 2 cycles in FETCH and 3 cycles in MEMREAD -> FETCH held 3 cycles with irWrite=0 until the ready cycle; MEMWB regWrite=1, resultSrc=01; immSrc=00.
3. sw (op 0100011) -> immSrc=01; memWrite=1 from MEMWRITE entry until memReady=1; adrSrc=1; return to FETCH; regWrite never 1.
4. beq with zero=1, then zero=0 -> immSrc=10; pcWrite=1 in BEQ only when zero=1; aluControl=001; 3-cycle latency.
5. jal (op 1101111) -> immSrc=11; pcWrite=1 in JAL; next state ALUWB with regWrite=1.
6. op 1111111 -> illegalOp pulses 1 cycle in DECODE, then FETCH. Separately, reset asserted during MEMWRITE -> memWrite drops low immediately and stateDbg=FETCH.
